// File: rtl/led_pattern_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_pkg
// Shared definitions for the multi-channel LED pattern generator:
//   - mode_e      : per-channel pattern selection (3-bit code)
//   - MODE_W      : width of the mode code
//   - HB_*        : bit positions, counted down from the phase MSB, that
//                   shape the heartbeat double pulse
//   - hb_active() : heartbeat decode from the selected phase bits
// Optional build macro used by the design: LED_BREATHE_EN (adds BREATHE mode).
// ---------------------------------------------------------------------------
package led_pattern_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF       = 3'd0,
      MODE_ON        = 3'd1,
      MODE_BLINK     = 3'd2,
      MODE_HEARTBEAT = 3'd3,
      MODE_PWM       = 3'd4,
      MODE_BREATHE   = 3'd5
   } mode_e;

   // Heartbeat: top HB_COARSE_BITS of the phase all ones, plus the two bits
   // at offsets HB_FINE_HI_OFS / HB_FINE_LO_OFS below the width all ones.
   // Bit W-4 is left free, which splits the lit window into two pulses.
   localparam int HB_COARSE_BITS = 3;
   localparam int HB_FINE_HI_OFS = 5;
   localparam int HB_FINE_BITS   = 2;

   function automatic logic hb_active(input logic [HB_COARSE_BITS-1:0] coarse,
                                      input logic [HB_FINE_BITS-1:0]   fine);
      return (&coarse) & (&fine);
   endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// led_pattern_gen_if
// Host-side configuration bus of the LED pattern generator.
//   cfg_we    : write strobe, one channel per cycle
//   cfg_sel   : target channel index (4 bits, out-of-range writes ignored)
//   cfg_mode  : pattern code (led_pattern_pkg::mode_e encoding)
//   cfg_level : PWM duty level for the target channel
//   phase_clr : synchronous restart of the shared phase/PWM counters
// Modports: master = host logic, slave = led_pattern_gen.
// ---------------------------------------------------------------------------
interface led_pattern_gen_if
   import led_pattern_pkg::*;
#(
   parameter int PWM_W = 8
);
   logic              cfg_we;
   logic [3:0]        cfg_sel;
   logic [MODE_W-1:0] cfg_mode;
   logic [PWM_W-1:0]  cfg_level;
   logic              phase_clr;

   modport master (output cfg_we, cfg_sel, cfg_mode, cfg_level, phase_clr);
   modport slave  (input  cfg_we, cfg_sel, cfg_mode, cfg_level, phase_clr);
endinterface

// File: rtl/led_channel.sv
// ---------------------------------------------------------------------------
// led_channel
// One LED channel: holds its mode/level configuration, decodes the "lit"
// condition from the shared phase-derived strobes and PWM counter, and
// registers the pin with the board polarity applied.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   we         : load mode_in/level_in this cycle (already channel-decoded)
//   mode_in    : pattern code
//   level_in   : PWM duty level
//   blink_on   : shared blink strobe (phase MSB)
//   hb_on      : shared heartbeat strobe
//   c_cnt      : shared PWM counter
//   duty_b     : shared breathe duty (only with LED_BREATHE_EN)
//   led        : registered LED pin
// Optional build macro: LED_BREATHE_EN.
// ---------------------------------------------------------------------------
module led_channel
   import led_pattern_pkg::*;
#(
   parameter int PWM_W      = 8,
   parameter int ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  mode_e            mode_in,
   input  logic [PWM_W-1:0] level_in,
   input  logic             blink_on,
   input  logic             hb_on,
   input  logic [PWM_W-1:0] c_cnt,
`ifdef LED_BREATHE_EN
   input  logic [PWM_W-1:0] duty_b,
`endif
   output logic             led
);

   localparam logic POL = (ACTIVE_LOW != 0);

   mode_e            mode_q;
   logic [PWM_W-1:0] level_q;
   logic             lit;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= MODE_OFF;
         level_q <= '0;
      end else if (we) begin
         mode_q  <= mode_in;
         level_q <= level_in;
      end
   end

   always_comb begin
      lit = 1'b0;
      case (mode_q)
         MODE_ON:        lit = 1'b1;
         MODE_BLINK:     lit = blink_on;
         MODE_HEARTBEAT: lit = hb_on;
         MODE_PWM:       lit = (c_cnt < level_q);
`ifdef LED_BREATHE_EN
         MODE_BREATHE:   lit = (c_cnt < duty_b);
`endif
         default:        lit = 1'b0;
      endcase
   end

   // Inactive pin level equals the polarity bit, so reset drives POL.
   always_ff @(posedge clk) begin
      if (rst) led <= POL;
      else     led <= lit ^ POL;
   end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Multi-channel LED driver. A shared phase counter (period 2^PRESCALE_W) and
// a shared PWM counter (period 2^PWM_W) keep every channel phase-locked;
// each channel selects OFF / ON / BLINK / HEARTBEAT / PWM (and BREATHE when
// built with LED_BREATHE_EN).
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (priority over phase_clr)
//   cfg  : configuration bus, led_pattern_gen_if.slave
//   led  : NUM_LEDS registered pins, polarity set by ACTIVE_LOW
// Optional build macro: LED_BREATHE_EN - shared triangle-wave duty (UP/DOWN
// FSM stepping once per PWM period) used by mode 5. Without it mode 5 is OFF.
// ---------------------------------------------------------------------------
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int NUM_LEDS   = 4,
   parameter int PRESCALE_W = 15,
   parameter int PWM_W      = 8,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                rst,
   led_pattern_gen_if.slave    cfg,
   output logic [NUM_LEDS-1:0] led
);

   logic [PRESCALE_W-1:0] p_cnt;
   logic [PWM_W-1:0]      c_cnt;
   logic                  blink_on;
   logic                  hb_on;

   // Both counters wrap naturally at their power-of-two periods.
   always_ff @(posedge clk) begin
      if (rst || cfg.phase_clr) begin
         p_cnt <= '0;
         c_cnt <= '0;
      end else begin
         p_cnt <= p_cnt + 1'b1;
         c_cnt <= c_cnt + 1'b1;
      end
   end

   assign blink_on = p_cnt[PRESCALE_W-1];
   assign hb_on    = hb_active(p_cnt[PRESCALE_W-1 -: HB_COARSE_BITS],
                               p_cnt[PRESCALE_W-HB_FINE_HI_OFS -: HB_FINE_BITS]);

`ifdef LED_BREATHE_EN
   localparam logic [0:0] ST_UP   = 1'b0;
   localparam logic [0:0] ST_DOWN = 1'b1;
   localparam logic [PWM_W-1:0] DUTY_MAX = '1;

   logic [0:0]       br_state;
   logic [PWM_W-1:0] duty_b;

   // Duty steps once per PWM period (on the last count), so each PWM window
   // sees a constant duty. Turn-around happens as the new value hits the end.
   always_ff @(posedge clk) begin
      if (rst || cfg.phase_clr) begin
         br_state <= ST_UP;
         duty_b   <= '0;
      end else if (c_cnt == DUTY_MAX) begin
         if (br_state == ST_UP) begin
            duty_b <= duty_b + 1'b1;
            if (duty_b == DUTY_MAX - 1'b1) br_state <= ST_DOWN;
         end else begin
            duty_b <= duty_b - 1'b1;
            if (duty_b == {{(PWM_W-1){1'b0}}, 1'b1}) br_state <= ST_UP;
         end
      end
   end
`endif

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_channel #(
         .PWM_W      (PWM_W),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .we       (cfg.cfg_we && (cfg.cfg_sel == 4'(i))),
         .mode_in  (mode_e'(cfg.cfg_mode)),
         .level_in (cfg.cfg_level),
         .blink_on (blink_on),
         .hb_on    (hb_on),
         .c_cnt    (c_cnt),
`ifdef LED_BREATHE_EN
         .duty_b   (duty_b),
`endif
         .led      (led[i])
      );
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Directed bench for led_pattern_gen with PRESCALE_W=8, PWM_W=4, NUM_LEDS=4,
// ACTIVE_LOW=1. obs[k] holds led sampled after the k-th edge following a
// configuration/phase_clr edge, so it reflects phase P=k-1, C=(k-1)%16.
// Build macro honoured: LED_BREATHE_EN (mode 5 expectations on ch3).
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;
   import led_pattern_pkg::*;

   localparam int NL = 4;
   localparam int PW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NL-1:0] led;

   led_pattern_gen_if #(.PWM_W(CW)) cfg_if ();

   led_pattern_gen #(
      .NUM_LEDS   (NL),
      .PRESCALE_W (PW),
      .PWM_W      (CW),
      .ACTIVE_LOW (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .cfg (cfg_if.slave),
      .led (led)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [NL-1:0] obs [0:600];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int observed, input int expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic record(input int n);
      for (int k = 1; k <= n; k++) begin
         tick();
         obs[k] = led;
      end
   endtask

   function automatic int lit_count(input int ch, input int lo, input int hi);
      int s = 0;
      for (int k = lo; k <= hi; k++)
         if (obs[k][ch] == 1'b0) s++;
      return s;
   endfunction

   function automatic int not_dark(input int lo, input int hi);
      int s = 0;
      for (int k = lo; k <= hi; k++)
         if (obs[k] !== 4'hF) s++;
      return s;
   endfunction

   task automatic write_cfg(input int sel, input int mode, input int level, input bit clr);
      cfg_if.cfg_we    = 1'b1;
      cfg_if.cfg_sel   = 4'(sel);
      cfg_if.cfg_mode  = 3'(mode);
      cfg_if.cfg_level = 4'(level);
      cfg_if.phase_clr = clr;
      tick();
      cfg_if.cfg_we    = 1'b0;
      cfg_if.phase_clr = 1'b0;
   endtask

   initial begin
      rst              = 1'b1;
      cfg_if.cfg_we    = 1'b0;
      cfg_if.cfg_sel   = '0;
      cfg_if.cfg_mode  = '0;
      cfg_if.cfg_level = '0;
      cfg_if.phase_clr = 1'b0;

      // Reset held three cycles, then idle with no writes.
      repeat (3) tick();
      chk("reset_led", int'(led), 15);
      rst = 1'b0;
      record(512);
      chk("idle_dark_512", not_dark(1, 512), 0);

      // Configure all channels; last write coincides with phase_clr.
      write_cfg(0, 2, 0, 1'b0);
      write_cfg(1, 3, 0, 1'b0);
      write_cfg(2, 4, 4, 1'b0);
      write_cfg(3, 5, 0, 1'b1);
      record(512);

      chk("blink_count", lit_count(0, 1, 256), 128);
      chk("blink_p7f",   int'(obs[128][0]), 1);
      chk("blink_p80",   int'(obs[129][0]), 0);
      chk("blink_pff",   int'(obs[256][0]), 0);
      chk("blink_wrap",  int'(obs[257][0]), 1);

      chk("hb_count", lit_count(1, 1, 256), 8);
      chk("hb_peb",   int'(obs[236][1]), 1);
      chk("hb_pec",   int'(obs[237][1]), 0);
      chk("hb_pf0",   int'(obs[241][1]), 1);
      chk("hb_pfc",   int'(obs[253][1]), 0);
      chk("hb_pff",   int'(obs[256][1]), 0);

      chk("pwm4_win",   lit_count(2, 1, 16), 4);
      chk("pwm4_c0",    int'(obs[1][2]), 0);
      chk("pwm4_c3",    int'(obs[4][2]), 0);
      chk("pwm4_c4",    int'(obs[5][2]), 1);
      chk("pwm4_total", lit_count(2, 1, 256), 64);

`ifdef LED_BREATHE_EN
      chk("br_win0",  lit_count(3, 1, 16), 0);
      chk("br_win4",  lit_count(3, 65, 80), 4);
      chk("br_win15", lit_count(3, 241, 256), 15);
      chk("br_win20", lit_count(3, 321, 336), 10);
      chk("br_win30", lit_count(3, 481, 496), 0);
      chk("br_win31", lit_count(3, 497, 512), 1);
`else
      chk("m5_dark", lit_count(3, 1, 512), 0);
`endif

      // PWM extremes on ch2.
      write_cfg(2, 4, 0, 1'b1);
      record(16);
      chk("pwm0_win", lit_count(2, 1, 16), 0);
      write_cfg(2, 4, 15, 1'b1);
      record(16);
      chk("pwm15_win", lit_count(2, 1, 16), 15);
      chk("pwm15_c15", int'(obs[16][2]), 1);

      // Out-of-range channel select must not touch any channel.
      write_cfg(5, 1, 15, 1'b1);
      record(256);
      chk("sel5_blink", lit_count(0, 1, 256), 128);
      chk("sel5_hb",    lit_count(1, 1, 256), 8);
      chk("sel5_pwm",   lit_count(2, 1, 256), 240);
`ifdef LED_BREATHE_EN
      chk("sel5_br0",  lit_count(3, 1, 16), 0);
      chk("sel5_br15", lit_count(3, 241, 256), 15);
`else
      chk("sel5_ch3", lit_count(3, 1, 256), 0);
`endif

      // Free-run into the lit half of blink, then clear the phase mid-period.
      record(200);
      chk("pre_clr_blink", int'(obs[200][0]), 0);
      cfg_if.phase_clr = 1'b1;
      tick();
      cfg_if.phase_clr = 1'b0;
      record(200);
      chk("clr_p0",   int'(obs[1][0]), 1);
      chk("clr_p7f",  int'(obs[128][0]), 1);
      chk("clr_p80",  int'(obs[129][0]), 0);
      chk("clr_c14",  int'(obs[15][2]), 0);
      chk("clr_c15",  int'(obs[16][2]), 1);

      // One-cycle write latency: P=200 here, heartbeat still dark.
      write_cfg(1, 1, 0, 1'b0);
      chk("wr_edge_n",  int'(led[1]), 1);
      tick();
      chk("wr_edge_n1", int'(led[1]), 0);

      // Reset mid-pattern: pins go dark at once and configuration is lost.
      rst = 1'b1;
      tick();
      chk("rst_mid_led", int'(led), 15);
      rst = 1'b0;
      record(300);
      chk("rst_cfg_lost", not_dark(1, 300), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
